// File: rtl/float_to_fixed.sv
// IEEE-754 single-precision to 32-bit two's-complement fixed-point converter.
// The mantissa is aligned by a 1-bit-per-cycle shifter sequenced by a small FSM.
module float_to_fixed (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] targetnumber,
  input  logic [4:0]  fixpointpos,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHL    = 2'd1,
    SHR    = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_OVF    = 2'd2
  } cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, cls_d, cls_s;
  logic [31:0]        mag_q, mag_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [31:0]        result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [7:0]         exp_s;
  logic signed [9:0]  sh_s;
  logic [4:0]         cnt_init_s;

  // Unpack the operand, derive the alignment shift and classify it.
  always_comb begin
    exp_s = targetnumber[30:23];
    sh_s  = $signed({2'b00, exp_s}) + $signed({5'b00000, fixpointpos}) - 10'sd150;
    if (sh_s[9]) begin
      cnt_init_s = 5'd0 - sh_s[4:0];
    end else begin
      cnt_init_s = sh_s[4:0];
    end
    if (exp_s == 8'd0) begin
      cls_s = CLS_ZERO;
    end else if (exp_s == 8'd255) begin
      cls_s = CLS_OVF;
    end else if (sh_s <= -10'sd24) begin
      cls_s = CLS_ZERO;
    end else if (sh_s >= 10'sd8) begin
      cls_s = CLS_OVF;
    end else begin
      cls_s = CLS_NORMAL;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((cls_s != CLS_NORMAL) || (sh_s == 10'sd0)) begin
            state_d = FINISH;
          end else if (sh_s[9]) begin
            state_d = SHR;
          end else begin
            state_d = SHL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHL, SHR: begin
        if (cnt_q == 5'd1) begin
          state_d = FINISH;
        end else begin
          state_d = state_q;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and the serial shifter datapath.
  always_comb begin
    mag_d  = mag_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    cls_d  = cls_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d  = {8'd0, 1'b1, targetnumber[22:0]};
          sign_d = targetnumber[31];
          cls_d  = cls_s;
          cnt_d  = cnt_init_s;
        end else begin
          mag_d = mag_q;
        end
      end
      SHL: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 5'd1;
      end
      SHR: begin
        mag_d = mag_q >> 1;
        cnt_d = cnt_q - 5'd1;
      end
      FINISH:  mag_d = mag_q;
      default: mag_d = mag_q;
    endcase
  end

  // Output logic: the result is written, and done raised, as FINISH is left.
  always_comb begin
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    busy_d     = (state_d != IDLE);
    if (state_q == FINISH) begin
      done_d = 1'b1;
      case (cls_q)
        CLS_ZERO: begin
          result_d   = 32'd0;
          overflow_d = 1'b0;
        end
        CLS_OVF: begin
          result_d   = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
          overflow_d = 1'b1;
        end
        CLS_NORMAL: begin
          result_d   = sign_q ? (32'd0 - mag_q) : mag_q;
          overflow_d = 1'b0;
        end
        default: begin
          result_d   = 32'd0;
          overflow_d = 1'b0;
        end
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q      <= 32'd0;
      cnt_q      <= 5'd0;
      sign_q     <= 1'b0;
      cls_q      <= CLS_NORMAL;
      result_q   <= 32'd0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      cls_q      <= cls_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed self-checking bench for float_to_fixed with hand-computed vectors.
module tb_float_to_fixed;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] targetnumber;
  logic [4:0]  fixpointpos;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int done_seen;

  float_to_fixed dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .targetnumber (targetnumber),
    .fixpointpos  (fixpointpos),
    .result       (result),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done, counting rising edges into lat.
  task automatic wait_done();
    while ((done !== 1'b1) && (lat < 64)) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Issues one operation, scrambles the inputs after acceptance, checks outcome.
  task automatic run_op(input string tag, input logic [31:0] num, input logic [4:0] fp,
                        input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat);
    @(negedge clk);
    start        = 1'b1;
    targetnumber = num;
    fixpointpos  = fp;
    @(posedge clk);
    #1;
    start        = 1'b0;
    targetnumber = 32'hDEAD_BEEF;
    fixpointpos  = 5'd17;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    wait_done();
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    targetnumber = 32'd0;
    fixpointpos  = 5'd0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, busy, done, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("p1_5_fp4", 32'h3FC0_0000, 5'd4, 32'h0000_0018, 1'b0, 20);
    @(posedge clk);
    #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);

    run_op("n2_5_fp8",   32'hC020_0000, 5'd8,  32'hFFFF_FD80, 1'b0, 15);
    run_op("p2e24_fp5",  32'h4B80_0000, 5'd5,  32'h2000_0000, 1'b0, 7);
    run_op("p2e31_fp0",  32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1);
    run_op("n2e31_fp0",  32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b1, 1);
    run_op("zero",       32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0, 1);
    run_op("pinf",       32'h7F80_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1);
    run_op("negzero",    32'h8000_0000, 5'd0,  32'h0000_0000, 1'b0, 1);
    run_op("half_fp0",   32'h3F00_0000, 5'd0,  32'h0000_0000, 1'b0, 1);
    run_op("one_fp23",   32'h3F80_0000, 5'd23, 32'h0080_0000, 1'b0, 1);
    run_op("one_fp0",    32'h3F80_0000, 5'd0,  32'h0000_0001, 1'b0, 24);
    run_op("n1_5_fp0",   32'hBFC0_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 24);
    run_op("n1_fp30",    32'hBF80_0000, 5'd30, 32'hC000_0000, 1'b0, 8);
    run_op("one_fp31",   32'h3F80_0000, 5'd31, 32'h7FFF_FFFF, 1'b1, 1);

    // A start while busy must be ignored.
    @(negedge clk);
    start        = 1'b1;
    targetnumber = 32'h3FC0_0000;
    fixpointpos  = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    start        = 1'b1;
    targetnumber = 32'h4B80_0000;
    fixpointpos  = 5'd5;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    wait_done();
    check("ignore_lat", 32'(lat), 32'd20);
    check("ignore_res", result, 32'h0000_0018);
    check("ignore_ovf", {31'd0, overflow}, 32'd0);

    // Async reset in the middle of a right shift aborts the operation.
    @(negedge clk);
    start        = 1'b1;
    targetnumber = 32'hC020_0000;
    fixpointpos  = 5'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {29'd0, busy, done, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);

    run_op("after_rst", 32'hC020_0000, 5'd8, 32'hFFFF_FD80, 1'b0, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
